// File: rtl/spi_flash_reader.sv
// Reads a block of 32-bit words from a SPI flash through a memory-mapped SPI
// controller: configure + select, send READ/address, then one dummy transfer per word.
module spi_flash_reader #(
  parameter logic [1:0]  SS_INDEX  = 2'd0,
  parameter logic [7:0]  READ_CMD  = 8'h03,
  parameter int unsigned XFER_WAIT = 34
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] flash_addr,
  input  logic [15:0] word_count,
  output logic        busy,
  output logic        done,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        spi_select,
  output logic        spi_rd,
  output logic [3:0]  spi_we,
  output logic [1:0]  spi_addr,
  output logic [31:0] spi_wdata,
  input  logic [31:0] spi_rdata,
  input  logic        spi_wbusy,
  input  logic        spi_rbusy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG,
    S_CMD,
    S_CMD_WAIT,
    S_DUMMY,
    S_XWAIT,
    S_RDATA,
    S_OUTPUT,
    S_RELEASE,
    S_DONE
  } state_e;

  typedef struct packed {
    logic        select;
    logic        rd;
    logic [3:0]  we;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } bus_t;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_IMM  = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;

  // Word mode, big-endian, slave select asserted on the chosen SS line.
  localparam logic [31:0] CFG_WORD = 32'h0101_0003 | {22'd0, SS_INDEX, 8'd0};

  localparam int WAIT_W = (XFER_WAIT > 1) ? $clog2(XFER_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(XFER_WAIT - 1);

  localparam bus_t BUS_IDLE = '0;

  function automatic bus_t bus_write(input logic [1:0] reg_sel, input logic [3:0] be,
                                     input logic [31:0] data);
    bus_t b;
    b        = BUS_IDLE;
    b.select = 1'b1;
    b.we     = be;
    b.addr   = reg_sel;
    b.wdata  = data;
    return b;
  endfunction

  function automatic bus_t bus_read(input logic [1:0] reg_sel);
    bus_t b;
    b        = BUS_IDLE;
    b.select = 1'b1;
    b.rd     = 1'b1;
    b.addr   = reg_sel;
    return b;
  endfunction

  state_e            state_q;
  bus_t              bus_q;
  logic              busy_q;
  logic              done_q;
  logic              out_valid_q;
  logic [31:0]       out_data_q;
  logic [23:0]       addr_q;
  logic [15:0]       remaining_q;
  logic [WAIT_W-1:0] wait_q;

  // NOTE: every bus strobe is a register loaded on the edge that enters its
  // state, so the controller sees glitch-free strobes held for the whole stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bus_q       <= BUS_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      addr_q      <= '0;
      remaining_q <= '0;
      wait_q      <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (word_count == 16'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              addr_q      <= flash_addr;
              remaining_q <= word_count;
              state_q     <= S_CFG;
              bus_q       <= bus_write(REG_CTRL, 4'b1111, CFG_WORD);
            end
          end
        end

        S_CFG: begin
          if (!spi_wbusy) begin
            state_q <= S_CMD;
            bus_q   <= bus_write(REG_DATA, 4'b1111, {READ_CMD, addr_q});
          end
        end

        S_CMD: begin
          if (!spi_wbusy) begin
            state_q <= S_CMD_WAIT;
            bus_q   <= BUS_IDLE;
            wait_q  <= WAIT_LOAD;
          end
        end

        S_CMD_WAIT: begin
          if (wait_q == '0) begin
            state_q <= S_DUMMY;
            bus_q   <= bus_write(REG_DATA, 4'b1111, 32'hFFFF_FFFF);
          end else begin
            wait_q <= wait_q - WAIT_W'(1);
          end
        end

        S_DUMMY: begin
          if (!spi_wbusy) begin
            state_q <= S_XWAIT;
            bus_q   <= BUS_IDLE;
            wait_q  <= WAIT_LOAD;
          end
        end

        S_XWAIT: begin
          if (wait_q == '0) begin
            state_q <= S_RDATA;
            bus_q   <= bus_read(REG_IMM);
          end else begin
            wait_q <= wait_q - WAIT_W'(1);
          end
        end

        S_RDATA: begin
          if (!spi_rbusy) begin
            out_data_q  <= spi_rdata;
            out_valid_q <= 1'b1;
            state_q     <= S_OUTPUT;
            bus_q       <= BUS_IDLE;
          end
        end

        // The next dummy transfer is only launched once the held word is taken.
        S_OUTPUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            remaining_q <= remaining_q - 16'd1;
            if (remaining_q == 16'd1) begin
              state_q <= S_RELEASE;
              bus_q   <= bus_write(REG_CTRL, 4'b1000, 32'h0000_0000);
            end else begin
              state_q <= S_DUMMY;
              bus_q   <= bus_write(REG_DATA, 4'b1111, 32'hFFFF_FFFF);
            end
          end
        end

        S_RELEASE: begin
          if (!spi_wbusy) begin
            state_q <= S_DONE;
            bus_q   <= BUS_IDLE;
            done_q  <= 1'b1;
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
          bus_q   <= BUS_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign spi_select = bus_q.select;
  assign spi_rd     = bus_q.rd;
  assign spi_we     = bus_q.we;
  assign spi_addr   = bus_q.addr;
  assign spi_wdata  = bus_q.wdata;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: a behavioural SPI controller + flash, a bus monitor,
// and an expected transaction/word list built directly from the block's rules.
module tb_spi_flash_reader;

  localparam int unsigned W   = 34;
  localparam logic [7:0]  CMD = 8'h03;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [23:0] flash_addr;
  logic [15:0] word_count;
  logic        busy;
  logic        done;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        spi_select;
  logic        spi_rd;
  logic [3:0]  spi_we;
  logic [1:0]  spi_addr;
  logic [31:0] spi_wdata;
  logic [31:0] spi_rdata;
  logic        spi_wbusy;
  logic        spi_rbusy;

  always #5 clk = ~clk;

  spi_flash_reader #(.SS_INDEX(2'd0), .READ_CMD(CMD), .XFER_WAIT(W)) dut (
    .clk(clk), .reset(reset), .start(start), .flash_addr(flash_addr),
    .word_count(word_count), .busy(busy), .done(done), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .spi_select(spi_select),
    .spi_rd(spi_rd), .spi_we(spi_we), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_rdata(spi_rdata), .spi_wbusy(spi_wbusy), .spi_rbusy(spi_rbusy)
  );

  typedef struct {
    logic        is_read;
    logic [1:0]  addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] mask;
  } ev_t;

  typedef struct {
    logic [23:0] addr;
    logic [15:0] count;
    int          p_wbusy;
    int          p_rbusy;
    int          p_ready;
    bit          fixed;
  } vec_t;

  ev_t         got_ev[$];
  ev_t         exp_ev[$];
  logic [31:0] got_words[$];
  logic [31:0] exp_words[$];
  int          gaps[$];

  int n_tests = 0;
  int n_fail  = 0;

  int gap_cnt, done_cnt, viol_strobe, viol_stall, viol_out, viol_done;
  int cmd_cycles, sel_cycles, rd_idx;
  logic [23:0] cmd_addr;
  logic        prev_stall, prev_valid, prev_ready, prev_done;
  logic [31:0] prev_data;
  logic [39:0] prev_bus;

  int   p_wbusy, p_rbusy, p_ready, hold_cmd_wbusy, hold_word, hold_ready;
  logic fixed_en;
  logic [31:0] fixed_word;

  // Flash contents: a fixed byte pattern of the byte address.
  function automatic logic [7:0] fbyte(input logic [23:0] a);
    logic [23:0] t;
    t = a * 24'd29 + (a >> 8) + 24'h00003C;
    return t[7:0];
  endfunction

  function automatic logic [31:0] flash_word(input logic [23:0] a);
    return {fbyte(a), fbyte(a + 24'd1), fbyte(a + 24'd2), fbyte(a + 24'd3)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // NOTE: the environment drives DUT inputs on the falling edge with blocking
  // assignments, so they are settled well before the rising edge samples them.
  always @(negedge clk) begin
    spi_wbusy = (int'($urandom_range(99)) < p_wbusy);
    if (hold_cmd_wbusy > 0 && spi_select && spi_we != 4'd0 && spi_addr == 2'd0 &&
        spi_wdata[31:24] == CMD) begin
      spi_wbusy = 1'b1;
      hold_cmd_wbusy--;
    end
    spi_rbusy = (int'($urandom_range(99)) < p_rbusy);
    out_ready = (int'($urandom_range(99)) < p_ready);
    if (out_valid && hold_ready > 0 && int'(got_words.size()) == hold_word) begin
      out_ready = 1'b0;
      hold_ready--;
    end
    spi_rdata = fixed_en ? fixed_word : flash_word(cmd_addr + 24'(4 * rd_idx));
  end

  // Bus monitor: samples pre-edge values at each rising edge.
  always @(posedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (!spi_select && (spi_we != 4'd0 || spi_rd)) viol_strobe++;
      if (spi_we != 4'd0 && spi_rd) viol_strobe++;
      if (spi_select && out_valid) viol_out++;
      if (prev_valid && !prev_ready && (!out_valid || out_data !== prev_data)) viol_out++;
      if (prev_stall && ({spi_select, spi_rd, spi_we, spi_addr, spi_wdata} !== prev_bus))
        viol_stall++;
      if (spi_select && spi_we != 4'd0 && spi_addr == 2'd0 && spi_wdata[31:24] == CMD)
        cmd_cycles++;
      if (spi_select) sel_cycles++;
      if (spi_select && spi_we != 4'd0 && !spi_wbusy) begin
        got_ev.push_back('{1'b0, spi_addr, spi_we, spi_wdata, 32'hFFFF_FFFF});
        if (spi_addr == 2'd0 && spi_wdata[31:24] == CMD) begin
          cmd_addr = spi_wdata[23:0];
          rd_idx   = 0;
        end
      end
      if (spi_select && spi_rd && !spi_rbusy) begin
        got_ev.push_back('{1'b1, spi_addr, spi_we, 32'h0, 32'h0});
        rd_idx++;
      end
      if (out_valid && out_ready) got_words.push_back(out_data);
      if (done) begin
        done_cnt++;
        if (prev_done) viol_done++;
      end
      if (!spi_select) gap_cnt++;
      else begin
        if (gap_cnt > 0) gaps.push_back(gap_cnt);
        gap_cnt = 0;
      end
      prev_stall = spi_select && ((spi_we != 4'd0 && spi_wbusy) || (spi_rd && spi_rbusy));
      prev_bus   = {spi_select, spi_rd, spi_we, spi_addr, spi_wdata};
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
      prev_done  = done;
    end
  end

  task automatic clear_mon();
    got_ev.delete();
    got_words.delete();
    gaps.delete();
    gap_cnt     = 0;
    done_cnt    = 0;
    viol_strobe = 0;
    viol_stall  = 0;
    viol_out    = 0;
    viol_done   = 0;
    cmd_cycles  = 0;
    sel_cycles  = 0;
  endtask

  // Expected bus traffic: cfg, READ+address, then dummy/read per word, then release.
  task automatic build_expected(input logic [23:0] addr, input logic [15:0] count);
    exp_ev.delete();
    exp_words.delete();
    if (count == 16'd0) return;
    exp_ev.push_back('{1'b0, 2'd2, 4'hF, 32'h0101_0003, 32'hFFFF_FFFF});
    exp_ev.push_back('{1'b0, 2'd0, 4'hF, {CMD, addr}, 32'hFFFF_FFFF});
    for (int i = 0; i < int'(count); i++) begin
      exp_ev.push_back('{1'b0, 2'd0, 4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
      exp_ev.push_back('{1'b1, 2'd1, 4'h0, 32'h0, 32'h0});
      exp_words.push_back(fixed_en ? fixed_word : flash_word(addr + 24'(4 * i)));
    end
    exp_ev.push_back('{1'b0, 2'd2, 4'b1000, 32'h0, 32'h0100_0000});
  endtask

  task automatic compare_results(input string tag, input logic [15:0] count);
    int n;
    check($sformatf("%s n_events", tag), 32'(got_ev.size()), 32'(exp_ev.size()));
    n = (got_ev.size() < exp_ev.size()) ? got_ev.size() : exp_ev.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s ev%0d kind/addr/we", tag, i),
            32'({got_ev[i].is_read, got_ev[i].addr, got_ev[i].we}),
            32'({exp_ev[i].is_read, exp_ev[i].addr, exp_ev[i].we}));
      check($sformatf("%s ev%0d wdata", tag, i),
            got_ev[i].wdata & exp_ev[i].mask, exp_ev[i].wdata & exp_ev[i].mask);
    end
    check($sformatf("%s n_words", tag), 32'(got_words.size()), 32'(exp_words.size()));
    n = (got_words.size() < exp_words.size()) ? got_words.size() : exp_words.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s word%0d", tag, i), got_words[i], exp_words[i]);
    check($sformatf("%s done_pulses", tag), 32'(done_cnt), 32'd1);
    check($sformatf("%s strobe_rules", tag), 32'(viol_strobe + viol_done), 32'd0);
    check($sformatf("%s stall_stable", tag), 32'(viol_stall), 32'd0);
    check($sformatf("%s out_hold", tag), 32'(viol_out), 32'd0);
    if (count == 16'd0) begin
      check($sformatf("%s no_select", tag), 32'(sel_cycles), 32'd0);
    end else begin
      check($sformatf("%s n_gaps", tag), 32'(gaps.size() >= 2), 32'd1);
      if (gaps.size() >= 2) begin
        check($sformatf("%s cmd_wait", tag), 32'(gaps[0]), 32'(W));
        check($sformatf("%s xfer_wait", tag), 32'(gaps[1]), 32'(W));
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s ctrl", tag),
          32'({busy, done, out_valid, spi_select, spi_rd, spi_we, spi_addr}), 32'd0);
    check($sformatf("%s out_data", tag), out_data, 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    while (busy && c < 2000) begin
      @(negedge clk);
      c++;
    end
    if (busy) begin
      check($sformatf("%s idle_timeout", tag), 32'(busy), 32'd0);
      pulse_reset();
    end
  endtask

  task automatic run_op(input logic [23:0] addr, input logic [15:0] count,
                        input int restart_cyc, input string tag);
    int budget;
    int cyc;
    wait_idle(tag);
    @(negedge clk);
    build_expected(addr, count);
    clear_mon();
    flash_addr = addr;
    word_count = count;
    start      = 1'b1;
    @(posedge clk);
    #1;
    gaps.delete();
    gap_cnt = 0;
    check($sformatf("%s busy", tag), 32'(busy), 32'd1);
    budget = 300 + int'(count) * (2 * int'(W) + 150);
    cyc    = 0;
    while (done_cnt == 0 && cyc < budget) begin
      @(negedge clk);
      if (cyc == restart_cyc) begin
        start      = 1'b1;
        flash_addr = 24'hABCDEF;
        word_count = 16'd7;
      end else begin
        start = 1'b0;
      end
      cyc++;
    end
    start = 1'b0;
    check($sformatf("%s done_seen", tag), 32'(done_cnt != 0), 32'd1);
    if (done_cnt == 0) pulse_reset();
    repeat (3) @(negedge clk);
    check($sformatf("%s busy_after", tag), 32'(busy), 32'd0);
    compare_results(tag, count);
  endtask

  vec_t vecs[6];

  initial begin
    int c;
    reset          = 1'b1;
    start          = 1'b0;
    flash_addr     = '0;
    word_count     = '0;
    out_ready      = 1'b0;
    spi_wbusy      = 1'b0;
    spi_rbusy      = 1'b0;
    spi_rdata      = '0;
    p_wbusy        = 0;
    p_rbusy        = 0;
    p_ready        = 100;
    hold_cmd_wbusy = 0;
    hold_word      = 0;
    hold_ready     = 0;
    fixed_en       = 1'b0;
    fixed_word     = 32'hDEAD_BEEF;
    cmd_addr       = '0;
    rd_idx         = 0;
    prev_bus       = '0;
    prev_data      = '0;
    prev_ready     = 1'b0;
    clear_mon();

    vecs[0] = '{24'h012345, 16'd1, 0, 0, 100, 1'b1};
    vecs[1] = '{24'h000000, 16'd2, 30, 30, 70, 1'b0};
    vecs[2] = '{24'hFFFFF8, 16'd3, 0, 50, 40, 1'b0};
    vecs[3] = '{24'h7A5C30, 16'd0, 0, 0, 100, 1'b0};
    vecs[4] = '{24'h100003, 16'd5, 50, 0, 100, 1'b0};
    vecs[5] = '{24'hFFFFFF, 16'd1, 20, 20, 20, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      p_wbusy  = vecs[i].p_wbusy;
      p_rbusy  = vecs[i].p_rbusy;
      p_ready  = vecs[i].p_ready;
      fixed_en = vecs[i].fixed;
      run_op(vecs[i].addr, vecs[i].count, -1, $sformatf("vec%0d", i));
    end
    fixed_en = 1'b0;

    // word_count = 0: done the cycle after start, no bus activity.
    p_wbusy = 0; p_rbusy = 0; p_ready = 100;
    wait_idle("zero");
    @(negedge clk);
    clear_mon();
    word_count = 16'd0;
    flash_addr = 24'h55AA55;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("zero done", 32'({done, busy}), 32'b11);
    @(posedge clk);
    #1;
    check("zero done_end", 32'({done, busy}), 32'b00);
    repeat (4) @(negedge clk);
    check("zero no_select", 32'(sel_cycles), 32'd0);

    // Consumer stalls 50 cycles on word 2 of 4.
    hold_word  = 1;
    hold_ready = 50;
    run_op(24'h2000C0, 16'd4, -1, "stall_ready");
    check("stall_ready consumed", 32'(hold_ready), 32'd0);
    hold_ready = 0;

    // Controller holds wbusy for 10 cycles during the READ command write.
    hold_cmd_wbusy = 10;
    run_op(24'h0F00F0, 16'd1, -1, "cmd_wbusy");
    check("cmd_wbusy cmd_cycles", 32'(cmd_cycles), 32'd11);
    hold_cmd_wbusy = 0;

    // Second start pulse during a 3-word read is ignored.
    p_wbusy = 20; p_rbusy = 20; p_ready = 60;
    run_op(24'h333330, 16'd3, 40, "restart");

    // Reset while waiting for the first data transfer.
    p_wbusy = 0; p_rbusy = 0; p_ready = 100;
    wait_idle("mid_reset");
    @(negedge clk);
    clear_mon();
    flash_addr = 24'h444440;
    word_count = 16'd1;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (got_ev.size() < 3 && c < 500) begin
      @(negedge clk);
      c++;
    end
    check("mid_reset reached_xwait", 32'(got_ev.size()), 32'd3);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_reset no_release", 32'(got_ev.size()), 32'd3);
    check("mid_reset no_done", 32'(done_cnt), 32'd0);
    run_op(24'h444440, 16'd1, -1, "after_reset");

    // Maximum count: first words stream and the block stays busy.
    wait_idle("max");
    @(negedge clk);
    clear_mon();
    flash_addr = 24'h0000A0;
    word_count = 16'hFFFF;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (got_words.size() < 3 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("max n_words", 32'(got_words.size()), 32'd3);
    for (int i = 0; i < 3 && i < int'(got_words.size()); i++)
      check($sformatf("max word%0d", i), got_words[i], flash_word(24'h0000A0 + 24'(4 * i)));
    check("max busy", 32'({busy, done}), 32'b10);
    check("max no_done", 32'(done_cnt), 32'd0);
    pulse_reset();

    // Randomised operations.
    for (int i = 0; i < 6; i++) begin
      p_wbusy = int'($urandom_range(60));
      p_rbusy = int'($urandom_range(60));
      p_ready = 10 + int'($urandom_range(90));
      run_op(24'($urandom), 16'($urandom_range(6, 1)), -1, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
